// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, one outstanding imem request,
// registered output slot and a one-entry skid buffer.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branchTaken,
  input  logic [31:0] branchAddr,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic [31:0] PCOut,
  output logic [31:0] instructionOut,
  output logic        fetchValid
);

  typedef enum logic [1:0] {
    REQ,
    DISCARD,
    FULL
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_addr, req_addr_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic [31:0] slot_instr, slot_instr_n;
  logic [31:0] slot_pc, slot_pc_n;
  logic        slot_valid, slot_valid_n;
  logic        bubble;
  logic        free;
  logic [31:0] pc_next;

  assign pc_next        = pc + PC_INC;
  assign free           = ~slot_valid | ~freeze;
  assign imemReq        = ~rst & (state != FULL);
  assign imemAddr       = req_addr;
  assign PCOut          = slot_pc;
  assign instructionOut = slot_instr;
  assign fetchValid     = slot_valid;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_addr_n   = req_addr;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    slot_instr_n = slot_instr;
    slot_pc_n    = slot_pc;
    slot_valid_n = slot_valid;
    bubble       = 1'b0;
    if (branchTaken) begin
      // redirect wins over freeze; an in-flight request must still drain
      pc_n         = branchAddr;
      bubble       = 1'b1;
      skid_instr_n = '0;
      skid_pc_n    = '0;
      if (state == REQ && !imemValid) begin
        state_n = DISCARD;
      end else if (state == DISCARD && !imemValid) begin
        state_n = DISCARD;
      end else begin
        state_n    = REQ;
        req_addr_n = branchAddr;
      end
    end else begin
      unique case (state)
        REQ: begin
          if (imemValid) begin
            pc_n = pc_next;
            if (free) begin
              slot_instr_n = imemData;
              slot_pc_n    = pc_next;
              slot_valid_n = 1'b1;
              req_addr_n   = pc_next;
            end else begin
              skid_instr_n = imemData;
              skid_pc_n    = pc_next;
              state_n      = FULL;
            end
          end else if (!freeze) begin
            bubble = 1'b1;
          end
        end
        FULL: begin
          if (!freeze) begin
            slot_instr_n = skid_instr;
            slot_pc_n    = skid_pc;
            slot_valid_n = 1'b1;
            skid_instr_n = '0;
            skid_pc_n    = '0;
            req_addr_n   = pc;
            state_n      = REQ;
          end
        end
        DISCARD: begin
          if (imemValid) begin
            req_addr_n = pc;
            state_n    = REQ;
          end
          if (!freeze) begin
            bubble = 1'b1;
          end
        end
        default: state_n = REQ;
      endcase
    end
    if (bubble) begin
      slot_instr_n = '0;
      slot_pc_n    = '0;
      slot_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REQ;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      skid_instr <= '0;
      skid_pc    <= '0;
      slot_instr <= '0;
      slot_pc    <= '0;
      slot_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_addr   <= req_addr_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      slot_instr <= slot_instr_n;
      slot_pc    <= slot_pc_n;
      slot_valid <= slot_valid_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: variable-latency memory,
// freeze/branch/reset stimulus, in-order stream scoreboard.
module tb_if_fetch_stage;

  localparam logic [31:0] RPC  = 32'h0;
  localparam logic [31:0] SALT = 32'h3C5A_9E17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchAddr = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid = 1'b0;
  logic [31:0] imemData = '0;
  logic [31:0] PCOut;
  logic [31:0] instructionOut;
  logic        fetchValid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] tail = RPC;
  int          total = 0;
  int          bad = 0;
  int          busy = 0;
  int          wcnt = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  int          vcount = 0;
  int          consumed = 0;

  logic        prev_req = 1'b0;
  logic        prev_val = 1'b0;
  logic        prev_rst = 1'b1;
  logic [31:0] prev_addr = '0;
  logic        hold_chk = 1'b0;
  logic [31:0] hold_pc = '0;
  logic [31:0] hold_in = '0;

  if_fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .branchTaken(branchTaken),
    .branchAddr(branchAddr),
    .imemReq(imemReq),
    .imemAddr(imemAddr),
    .imemValid(imemValid),
    .imemData(imemData),
    .PCOut(PCOut),
    .instructionOut(instructionOut),
    .fetchValid(fetchValid)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ SALT;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // one clock of stimulus: controls first, then the memory model
  task automatic cycle(input logic r, input logic f, input logic b,
                       input logic [31:0] ba);
    @(posedge clk);
    #1;
    rst = r;
    freeze = f;
    branchTaken = b;
    branchAddr = ba;
    if (r) begin
      sb.delete();
      tail = RPC;
    end else if (b) begin
      sb.delete();
      tail = ba;
    end
    while (sb.size() < 4) begin
      sb.push_back('{pc: tail + 32'd4, instr: memf(tail)});
      tail = tail + 32'd4;
    end
    #1;
    if (r) begin
      busy = 0;
      imemValid = 1'($urandom_range(0, 1));
      imemData = 32'hDEAD_BEEF;
    end else begin
      if (imemReq && busy == 0) begin
        busy = 1;
        wcnt = $urandom_range(lat_min, lat_max);
      end
      if (imemReq && wcnt == 0) begin
        imemValid = 1'b1;
        imemData = memf(imemAddr);
        busy = 0;
      end else begin
        imemValid = 1'b0;
        imemData = $urandom;
        if (busy != 0 && wcnt > 0) wcnt--;
      end
    end
  endtask

  // monitor: protocol, bubble, freeze-hold and in-order stream checks
  initial begin
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        chk("rst_valid", {31'd0, fetchValid}, 32'd0);
        chk("rst_pc", PCOut, 32'd0);
        chk("rst_instr", instructionOut, 32'd0);
        if (rst) begin
          chk("rst_req", {31'd0, imemReq}, 32'd0);
        end else begin
          chk("boot_req", {31'd0, imemReq}, 32'd1);
          chk("boot_addr", imemAddr, RPC);
        end
      end else begin
        if (hold_chk) begin
          chk("hold_valid", {31'd0, fetchValid}, 32'd1);
          chk("hold_pc", PCOut, hold_pc);
          chk("hold_instr", instructionOut, hold_in);
        end
        if (prev_req && !prev_val) begin
          chk("addr_stable", imemAddr, prev_addr);
          if (!rst) chk("req_held", {31'd0, imemReq}, 32'd1);
        end
      end
      if (!fetchValid) begin
        chk("bubble_pc", PCOut, 32'd0);
        chk("bubble_instr", instructionOut, 32'd0);
      end else if (!freeze && !branchTaken && !rst) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got pc %h want nothing", PCOut);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("stream_pc", PCOut, e.pc);
          chk("stream_instr", instructionOut, e.instr);
          consumed++;
        end
      end
      if (fetchValid) vcount++;
      prev_req = imemReq;
      prev_val = imemValid;
      prev_addr = imemAddr;
      prev_rst = rst;
      hold_chk = fetchValid && freeze && !branchTaken && !rst;
      hold_pc = PCOut;
      hold_in = instructionOut;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ba;
    logic        f, b, r;
    lat_min = 0;
    lat_max = 0;
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    vcount = 0;
    repeat (50) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("zero_wait_thru", 32'(vcount >= 47), 32'd1);
    lat_min = 2;
    lat_max = 2;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    vcount = 0;
    repeat (60) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("lat3_thru", 32'(vcount >= 18 && vcount <= 20), 32'd1);
    lat_min = 0;
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 99) < 40);
      b = !r && ($urandom_range(0, 99) < 5);
      case ($urandom_range(0, 3))
        0: ba = 32'hFFFF_FFF4;
        1: ba = 32'h0000_0100;
        default: ba = $urandom & 32'hFFFF_FFFC;
      endcase
      cycle(r, f, b, ba);
    end
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    chk("consumed", 32'(consumed > 300), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
